// File: rtl/hazard_pkg.sv
// Shared types, select encodings and parameter checks for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LUSE    = 2'd1,
        MD_BUSY = 2'd2
    } hz_state_t;

    // Which priority rule currently drives the stall/flush outputs.
    typedef enum logic [2:0] {
        WIN_NONE = 3'd0,
        WIN_EXC  = 3'd1,
        WIN_DC   = 3'd2,
        WIN_MD   = 3'd3,
        WIN_PRED = 3'd4,
        WIN_LUSE = 3'd5,
        WIN_JUMP = 3'd6
    } hz_win_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    localparam int unsigned LUSE_CYC_MIN = 1;
    localparam int unsigned LUSE_CYC_MAX = 3;

    function automatic bit load_use_cyc_ok(input int unsigned cyc);
        return (cyc >= LUSE_CYC_MIN) && (cyc <= LUSE_CYC_MAX);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one E-stage source operand; the M stage beats the W stage.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_reg,
    input  logic              reg_write_enM,
    input  logic [REG_AW-1:0] reg_writeM,
    input  logic              reg_write_enW,
    input  logic [REG_AW-1:0] reg_writeW,
    output logic [1:0]        fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (src_reg != '0) begin
            if (reg_write_enM && (reg_writeM == src_reg)) begin
                fwd_sel = FWD_M;
            end else if (reg_write_enW && (reg_writeW == src_reg)) begin
                fwd_sel = FWD_W;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding, load-use, mult/div and flush sequencing.
// Optional HAZARD_PERF_EN adds saturating performance counters on the perf_* outputs.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned LOAD_USE_CYC = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      d_cache_stall,
    input  logic                      i_cache_stall,
    input  logic                      md_startE,
    input  logic                      md_readyE,
    input  logic                      flush_jump_conflictE,
    input  logic                      flush_pred_failedM,
    input  logic                      flush_exceptionM,
    input  logic [NUM_SRC*REG_AW-1:0] src_regD,
    input  logic [NUM_SRC*REG_AW-1:0] src_regE,
    input  logic [NUM_SRC-1:0]        src_validD,
    input  logic                      reg_write_enE,
    input  logic                      reg_write_enM,
    input  logic                      reg_write_enW,
    input  logic [REG_AW-1:0]         reg_writeE,
    input  logic [REG_AW-1:0]         reg_writeM,
    input  logic [REG_AW-1:0]         reg_writeW,
    input  logic                      mem_read_enE,
    output logic                      stallF,
    output logic                      stallD,
    output logic                      stallE,
    output logic                      stallM,
    output logic                      stallW,
    output logic                      flushF,
    output logic                      flushD,
    output logic                      flushE,
    output logic                      flushM,
    output logic                      flushW,
    output logic [2*NUM_SRC-1:0]      fwd_selE,
    output logic                      md_cancel,
    output logic [1:0]                hz_state,
    output logic [31:0]               perf_luse_cyc,
    output logic [31:0]               perf_md_cyc,
    output logic [31:0]               perf_dc_cyc,
    output logic [31:0]               perf_flush_cnt
);

    if (!load_use_cyc_ok(LOAD_USE_CYC)) begin : g_bad_luse_cyc
        $error("LOAD_USE_CYC must be in 1..3");
    end

    // The IDLE->LUSE cycle is itself the first bubble, so LUSE holds for LOAD_USE_CYC-1 cycles.
    localparam logic [1:0] CNT_INIT = (LOAD_USE_CYC > 1) ? 2'(LOAD_USE_CYC - 2) : 2'd0;

    hz_state_t  state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       src_hit, luse, md_pending, luse_active;
    hz_win_t    win;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd (
            .src_reg       (src_regE[i*REG_AW +: REG_AW]),
            .reg_write_enM (reg_write_enM),
            .reg_writeM    (reg_writeM),
            .reg_write_enW (reg_write_enW),
            .reg_writeW    (reg_writeW),
            .fwd_sel       (fwd_selE[2*i +: 2])
        );
    end

    always_comb begin
        src_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_validD[i] && (src_regD[i*REG_AW +: REG_AW] == reg_writeE)) begin
                src_hit = 1'b1;
            end
        end
    end

    assign luse        = mem_read_enE && reg_write_enE && (reg_writeE != '0) && src_hit;
    assign md_pending  = !md_readyE && ((state_q == MD_BUSY) || ((state_q == IDLE) && md_startE));
    assign luse_active = (state_q == LUSE) || ((state_q == IDLE) && luse);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_exceptionM) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!d_cache_stall) begin
            unique case (state_q)
                IDLE: begin
                    if (md_startE) begin
                        if (!md_readyE) state_d = MD_BUSY;
                    end else if (luse && (LOAD_USE_CYC > 1)) begin
                        state_d = LUSE;
                        cnt_d   = CNT_INIT;
                    end
                end
                LUSE: begin
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 2'd1;
                end
                MD_BUSY: begin
                    if (md_readyE) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        win = WIN_NONE;
        if (flush_exceptionM)          win = WIN_EXC;
        else if (d_cache_stall)        win = WIN_DC;
        else if (md_pending)           win = WIN_MD;
        else if (flush_pred_failedM)   win = WIN_PRED;
        else if (luse_active)          win = WIN_LUSE;
        else if (flush_jump_conflictE) win = WIN_JUMP;
    end

    always_comb begin
        {stallF, stallD, stallE, stallM, stallW} = '0;
        {flushF, flushD, flushE, flushM, flushW} = '0;
        md_cancel = 1'b0;
        unique case (win)
            WIN_EXC: begin
                {flushD, flushE, flushM} = '1;
                stallM    = d_cache_stall;
                stallW    = d_cache_stall;
                md_cancel = (state_q == MD_BUSY);
            end
            WIN_DC:   {stallF, stallD, stallE, stallM, stallW} = '1;
            WIN_MD: begin
                {stallF, stallD, stallE} = '1;
                flushM = 1'b1;
                flushD = flush_pred_failedM;
            end
            WIN_PRED: {flushD, flushE} = '1;
            WIN_LUSE: begin
                {stallF, stallD} = '1;
                flushE = 1'b1;
            end
            WIN_JUMP: flushD = 1'b1;
            default: ;
        endcase
        if (i_cache_stall) begin
            stallF = 1'b1;
            if (!stallD) flushD = 1'b1;
        end
    end

    assign hz_state = state_q;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_luse_cyc  <= '0;
            perf_md_cyc    <= '0;
            perf_dc_cyc    <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (win == WIN_LUSE) perf_luse_cyc <= sat_inc(perf_luse_cyc);
            if (win == WIN_MD)   perf_md_cyc   <= sat_inc(perf_md_cyc);
            if (win == WIN_DC)   perf_dc_cyc   <= sat_inc(perf_dc_cyc);
            if ((win == WIN_EXC) || (win == WIN_PRED)) perf_flush_cnt <= sat_inc(perf_flush_cnt);
        end
    end
`else
    assign perf_luse_cyc  = '0;
    assign perf_md_cyc    = '0;
    assign perf_dc_cyc    = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LOAD_USE_CYC 1 and 2) checked against a bubble/busy model.
module tb_pipe_hazard_ctrl;

    localparam int NS = 2;
    localparam int AW = 5;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    logic d_cache_stall, i_cache_stall, md_startE, md_readyE;
    logic flush_jump_conflictE, flush_pred_failedM, flush_exceptionM;
    logic [NS*AW-1:0] src_regD, src_regE;
    logic [NS-1:0] src_validD;
    logic reg_write_enE, reg_write_enM, reg_write_enW, mem_read_enE;
    logic [AW-1:0] reg_writeE, reg_writeM, reg_writeW;

    logic [1:0] stallF, stallD, stallE, stallM, stallW;
    logic [1:0] flushF, flushD, flushE, flushM, flushW, md_cancel;
    logic [2*NS-1:0] fwd [2];
    logic [1:0] hz [2];
    logic [31:0] p_luse [2], p_md [2], p_dc [2], p_fl [2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        pipe_hazard_ctrl #(.NUM_SRC(NS), .REG_AW(AW), .LOAD_USE_CYC(k + 1)) u_dut (
            .clk(clk), .resetn(resetn),
            .d_cache_stall(d_cache_stall), .i_cache_stall(i_cache_stall),
            .md_startE(md_startE), .md_readyE(md_readyE),
            .flush_jump_conflictE(flush_jump_conflictE), .flush_pred_failedM(flush_pred_failedM),
            .flush_exceptionM(flush_exceptionM),
            .src_regD(src_regD), .src_regE(src_regE), .src_validD(src_validD),
            .reg_write_enE(reg_write_enE), .reg_write_enM(reg_write_enM), .reg_write_enW(reg_write_enW),
            .reg_writeE(reg_writeE), .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
            .mem_read_enE(mem_read_enE),
            .stallF(stallF[k]), .stallD(stallD[k]), .stallE(stallE[k]), .stallM(stallM[k]), .stallW(stallW[k]),
            .flushF(flushF[k]), .flushD(flushD[k]), .flushE(flushE[k]), .flushM(flushM[k]), .flushW(flushW[k]),
            .fwd_selE(fwd[k]), .md_cancel(md_cancel[k]), .hz_state(hz[k]),
            .perf_luse_cyc(p_luse[k]), .perf_md_cyc(p_md[k]), .perf_dc_cyc(p_dc[k]), .perf_flush_cnt(p_fl[k])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: md_busy flag plus remaining extra load-use bubbles; perf as plain cycle tallies.
    bit m_busy [2];
    int m_left [2];
    int m_pl [2], m_pm [2], m_pd [2], m_pf [2];
    int stallD_seen [2], stallE_seen [2];

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0; m_left[k] = 0;
            m_pl[k] = 0; m_pm[k] = 0; m_pd[k] = 0; m_pf[k] = 0;
        end
    endtask

    function automatic bit luse_ref();
        bit hit = 1'b0;
        for (int i = 0; i < NS; i++)
            if (src_validD[i] && (src_regD[i*AW +: AW] == reg_writeE)) hit = 1'b1;
        return mem_read_enE && reg_write_enE && (reg_writeE != 0) && hit;
    endfunction

    function automatic logic [2*NS-1:0] fwd_ref();
        logic [2*NS-1:0] r = '0;
        logic [AW-1:0] s;
        for (int i = 0; i < NS; i++) begin
            s = src_regE[i*AW +: AW];
            if (s == 0)                             r[2*i +: 2] = 2'b00;
            else if (reg_write_enM && reg_writeM == s) r[2*i +: 2] = 2'b01;
            else if (reg_write_enW && reg_writeW == s) r[2*i +: 2] = 2'b10;
        end
        return r;
    endfunction

    function automatic int winner(input int k);
        bit in_md = m_busy[k];
        bit in_lu = (m_left[k] > 0);
        bit idle  = !in_md && !in_lu;
        if (flush_exceptionM) return 1;
        if (d_cache_stall) return 2;
        if (!md_readyE && (in_md || (idle && md_startE))) return 3;
        if (flush_pred_failedM) return 4;
        if (in_lu || (idle && luse_ref())) return 5;
        if (flush_jump_conflictE) return 6;
        return 0;
    endfunction

    // {stallF,D,E,M,W, flushF,D,E,M,W, md_cancel}
    function automatic logic [10:0] exp_ctl(input int k);
        logic [4:0] st = '0;
        logic [4:0] fl = '0;
        logic mc = 1'b0;
        case (winner(k))
            1: begin fl = 5'b01110; st = {3'b000, d_cache_stall, d_cache_stall}; mc = m_busy[k]; end
            2: st = 5'b11111;
            3: begin st = 5'b11100; fl = {1'b0, flush_pred_failedM, 1'b0, 1'b1, 1'b0}; end
            4: fl = 5'b01100;
            5: begin st = 5'b11000; fl = 5'b00100; end
            6: fl = 5'b01000;
            default: ;
        endcase
        if (i_cache_stall) begin
            st[4] = 1'b1;
            if (!st[3]) fl[3] = 1'b1;
        end
        return {st, fl, mc};
    endfunction

    task automatic step_model();
        int w;
        bit lu;
        for (int k = 0; k < 2; k++) begin
            w  = winner(k);
            lu = luse_ref();
            case (w)
                1, 4: m_pf[k]++;
                2: m_pd[k]++;
                3: m_pm[k]++;
                5: m_pl[k]++;
                default: ;
            endcase
            if (flush_exceptionM) begin
                m_busy[k] = 1'b0; m_left[k] = 0;
            end else if (!d_cache_stall) begin
                if (m_busy[k])         begin if (md_readyE) m_busy[k] = 1'b0; end
                else if (m_left[k] > 0) m_left[k]--;
                else if (md_startE)     m_busy[k] = !md_readyE;
                else if (lu)            m_left[k] = k; // instance k has LOAD_USE_CYC = k+1
            end
        end
    endtask

    // Called at a negedge right after inputs are driven; returns at the next negedge.
    task automatic cycle();
        logic [10:0] got;
        logic [1:0] exp_hz;
        #1;
        for (int k = 0; k < 2; k++) begin
            got = {stallF[k], stallD[k], stallE[k], stallM[k], stallW[k],
                   flushF[k], flushD[k], flushE[k], flushM[k], flushW[k], md_cancel[k]};
            exp_hz = m_busy[k] ? 2'd2 : (m_left[k] > 0) ? 2'd1 : 2'd0;
            check($sformatf("ctl%0d", k), got, exp_ctl(k));
            check($sformatf("fwd%0d", k), fwd[k], fwd_ref());
            check($sformatf("hz%0d", k), hz[k], exp_hz);
            check($sformatf("perf%0d", k), {p_luse[k], p_md[k], p_dc[k], p_fl[k]},
                  PERF ? {32'(m_pl[k]), 32'(m_pm[k]), 32'(m_pd[k]), 32'(m_pf[k])} : 128'd0);
            stallD_seen[k] += int'(stallD[k]);
            stallE_seen[k] += int'(stallE[k]);
        end
        @(posedge clk);
        step_model();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        {d_cache_stall, i_cache_stall, md_startE, md_readyE} = '0;
        {flush_jump_conflictE, flush_pred_failedM, flush_exceptionM} = '0;
        src_regD = '0; src_regE = '0; src_validD = '0;
        {reg_write_enE, reg_write_enM, reg_write_enW, mem_read_enE} = '0;
        reg_writeE = '0; reg_writeM = '0; reg_writeW = '0;
    endtask

    task automatic clear_seen();
        for (int k = 0; k < 2; k++) begin stallD_seen[k] = 0; stallE_seen[k] = 0; end
    endtask

    task automatic set_load_use();
        mem_read_enE = 1'b1; reg_write_enE = 1'b1; reg_writeE = 5'd4;
        src_regD = {5'd4, 5'd7}; src_validD = 2'b10;
    endtask

    initial begin
        idle_inputs();
        reset_model();
        clear_seen();
        resetn = 1'b0;
        @(negedge clk); #1;
        check("rst_hz0", hz[0], 2'd0);
        check("rst_stall", {stallF, stallD, stallE}, 6'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Forwarding: M beats W; r0 never forwards.
        src_regE = {5'd9, 5'd3}; reg_write_enM = 1'b1; reg_writeM = 5'd3;
        reg_write_enW = 1'b1; reg_writeW = 5'd3;
        #1 check("fwd_m_over_w", fwd[0][1:0], 2'b01);
        cycle();
        src_regE = '0; reg_writeM = '0; reg_writeW = '0;
        #1 check("fwd_r0", fwd[0], 4'b0000);
        cycle();
        idle_inputs();

        // Load-use: bubble length equals LOAD_USE_CYC.
        clear_seen();
        set_load_use();
        cycle();
        idle_inputs();
        repeat (4) cycle();
        check("luse_len1", stallD_seen[0], 1);
        check("luse_len2", stallD_seen[1], 2);

        // Mult/div for 10 cycles, then again with a 3-cycle D-cache miss inside.
        for (int pass = 0; pass < 2; pass++) begin
            clear_seen();
            for (int c = 0; c <= 10; c++) begin
                md_startE = (c == 0);
                md_readyE = (c == 10);
                d_cache_stall = (pass == 1) && (c >= 3) && (c <= 5);
                cycle();
            end
            idle_inputs();
            #1;
            check($sformatf("md_len_p%0d", pass), stallE_seen[0], 10);
            check($sformatf("md_exit_p%0d", pass), hz[0], 2'd0);
            @(negedge clk);
        end

        // Exception while MD_BUSY cancels the unit and returns to IDLE.
        md_startE = 1'b1; cycle(); md_startE = 1'b0;
        cycle();
        flush_exceptionM = 1'b1;
        cycle();
        flush_exceptionM = 1'b0;
        #1 check("exc_to_idle", hz[0], 2'd0);
        @(negedge clk);

        // Branch mispredict under MD_BUSY, then mispredict together with load-use.
        md_startE = 1'b1; cycle(); md_startE = 1'b0;
        flush_pred_failedM = 1'b1; cycle();
        md_readyE = 1'b1; flush_pred_failedM = 1'b0; cycle();
        idle_inputs();
        set_load_use(); flush_pred_failedM = 1'b1;
        #1 check("pred_luse_nostall", {stallD[0], flushD[0], flushE[0]}, 3'b011);
        cycle();
        idle_inputs();
        repeat (2) cycle();

        // Asynchronous reset in the middle of a load-use bubble.
        set_load_use(); cycle(); idle_inputs();
        #1 check("mid_luse_hz1", hz[1], 2'd1);
        #1 resetn = 1'b0;
        #1 check("async_rst_hz", {hz[1], hz[0]}, 4'd0);
        check("async_rst_perf", {p_luse[0], p_md[0], p_dc[0], p_fl[0]}, 128'd0);
        reset_model();
        @(negedge clk);
        resetn = 1'b1;
        d_cache_stall = 1'b1;
        repeat (5) cycle();
        d_cache_stall = 1'b0;
        #1 check("perf_dc5", p_dc[0], PERF ? 32'd5 : 32'd0);
        @(negedge clk);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            flush_exceptionM     = ($urandom_range(0, 15) == 0);
            d_cache_stall        = ($urandom_range(0, 7) == 0);
            i_cache_stall        = ($urandom_range(0, 7) == 0);
            md_startE            = ($urandom_range(0, 7) == 0);
            md_readyE            = ($urandom_range(0, 3) == 0);
            flush_pred_failedM   = ($urandom_range(0, 9) == 0);
            flush_jump_conflictE = ($urandom_range(0, 7) == 0);
            mem_read_enE         = $urandom_range(0, 1) == 1;
            reg_write_enE        = $urandom_range(0, 3) != 0;
            reg_write_enM        = $urandom_range(0, 1) == 1;
            reg_write_enW        = $urandom_range(0, 1) == 1;
            reg_writeE           = 5'($urandom_range(0, 3));
            reg_writeM           = 5'($urandom_range(0, 3));
            reg_writeW           = 5'($urandom_range(0, 3));
            src_regD             = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            src_regE             = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            src_validD           = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
